lfsr_gen: RTL and testbench

Parametrised Fibonacci LFSR stimulus generator. It is the successor to the fixed 22-bit generator that feeds the filter and accumulator test path. It adds configurable width and tap polynomial, plus run/step/load/hold modes. It also measures the sequence period, detects and recovers from lock-up, and produces the registered period-boundary `clear_accum` pulse for the downstream accumulator.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_period_ctr.sv | 43 ++++
 rtl/lfsr_gen.sv | 69 ++++++
 tb/tb_lfsr_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and the Fibonacci next-state function for the LFSR stimulus generator.
package lfsr_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic [21:0] TAPS_22 = 22'h206080;
    localparam logic [21:0] SEED_22 = 22'h000001;
    localparam logic [3:0]  TAPS_4  = 4'h9;
    localparam logic [3:0]  SEED_4  = 4'h1;

    // Operates on a zero-extended 32-bit state; callers keep the low WIDTH bits.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
        return {state[30:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_period_ctr.sv
// Saturating step counter: captures the period on each return to SEED and strobes clear_accum.
module lfsr_period_ctr #(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             advance,
    input  logic             load,
    input  logic             wrap,
    output logic [WIDTH-1:0] period_len,
    output logic             clear_accum
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;

    // All-ones is sticky so an unmeasurable period reads back as saturated.
    assign count_inc = (count == CNT_MAX) ? CNT_MAX : count + WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            period_len  <= '0;
            clear_accum <= 1'b0;
        end else begin
            clear_accum <= 1'b0;
            if (load) begin
                count <= '0;
            end else if (advance) begin
                if (wrap) begin
                    period_len  <= count_inc;
                    count       <= '0;
                    clear_accum <= 1'b1;
                end else begin
                    count <= count_inc;
                end
            end
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with run/step/load/hold modes, lock-up recovery and period measurement.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 22,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_22,
    parameter logic [WIDTH-1:0] SEED  = SEED_22
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clk_en,
    input  logic [1:0]              mode,
    input  logic                    step,
    input  logic [WIDTH-1:0]        seed_in,
    output logic signed [WIDTH-1:0] y,
    output logic                    y_valid,
    output logic                    clear_accum,
    output logic [WIDTH-1:0]        period_len,
    output logic                    lockup_err
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] next_state;
    logic             advance;
    logic             load;
    logic             wrap;

    assign next_state = WIDTH'(lfsr_next(32'(state), 32'(TAPS)));

    // Load mode decodes separately, so a step held high during a load never advances.
    assign load    = clk_en && (mode == MODE_LOAD);
    assign advance = clk_en && ((mode == MODE_RUN) || ((mode == MODE_STEP) && step));
    assign wrap    = (next_state == SEED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SEED;
            y_valid    <= 1'b0;
            lockup_err <= 1'b0;
        end else begin
            y_valid <= advance || load;
            if (load) begin
                if (seed_in == '0) begin
                    state      <= SEED;
                    lockup_err <= 1'b1;
                end else begin
                    state <= seed_in;
                end
            end else if (advance) begin
                state <= next_state;
            end
        end
    end

    assign y = state;

    lfsr_period_ctr #(
        .WIDTH (WIDTH)
    ) u_period_ctr (
        .clk         (clk),
        .reset_n     (reset_n),
        .advance     (advance),
        .load        (load),
        .wrap        (wrap),
        .period_len  (period_len),
        .clear_accum (clear_accum)
    );

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed scoreboard bench for lfsr_gen in the 4-bit configuration (TAPS=9, SEED=1).
module tb_lfsr_gen;
    import lfsr_pkg::*;

    localparam int W  = 4;
    localparam int EW = 2 * W + 2;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                clk_en = 1'b0;
    logic [1:0]          mode = MODE_HOLD;
    logic                step = 1'b0;
    logic [W-1:0]        seed_in = '0;
    logic signed [W-1:0] y;
    logic [W-1:0]        y_u;
    logic                y_valid;
    logic                clear_accum;
    logic [W-1:0]        period_len;
    logic                lockup_err;

    assign y_u = y;

    lfsr_gen #(
        .WIDTH (W),
        .TAPS  (TAPS_4),
        .SEED  (SEED_4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_en      (clk_en),
        .mode        (mode),
        .step        (step),
        .seed_in     (seed_in),
        .y           (y),
        .y_valid     (y_valid),
        .clear_accum (clear_accum),
        .period_len  (period_len),
        .lockup_err  (lockup_err)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_v;
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int clr_cnt = 0;
    int clr_last = 0;
    int clr_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // monitor: pops one expectation per y_valid strobe
    always @(negedge clk) begin
        cyc++;
        if (clear_accum) begin
            clr_cnt++;
            clr_prev = clr_last;
            clr_last = cyc;
        end
        if (y_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_y_valid", 32'd1, 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                check("y_clr_plen_lock", 32'({y_u, clear_accum, period_len, lockup_err}), 32'(exp_v));
            end
        end else if (clear_accum) begin
            check("clear_without_valid", 32'd1, 32'd0);
        end
    end

    // driver tasks
    task automatic expect_out(input logic [W-1:0] ey, input logic ec, input logic [W-1:0] ep, input logic el);
        exp_q.push_back({ey, ec, ep, el});
    endtask

    task automatic drive(input logic en, input logic [1:0] m, input logic st, input logic [W-1:0] sd);
        clk_en  = en;
        mode    = m;
        step    = st;
        seed_in = sd;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] run_seq[15]  = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                                   4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [W-1:0] step_seq[3]  = '{4'h3, 4'h7, 4'hF};
    logic [W-1:0] load_seq[9]  = '{4'h5, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [W-1:0] lock_seq[13] = '{4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1,
                                   4'h3, 4'h7, 4'hF, 4'hE, 4'hD};

    initial begin
        int v0;
        int c0;

        // reset held while requesting free-run: state must stay at SEED
        reset_n = 1'b0;
        clk_en  = 1'b1;
        mode    = MODE_RUN;
        repeat (3) @(posedge clk);
        #3;
        check("reset_y", 32'(y_u), 32'h1);
        check("reset_y_valid", 32'(y_valid), 32'h0);
        check("reset_clear_accum", 32'(clear_accum), 32'h0);
        check("reset_period_len", 32'(period_len), 32'h0);
        check("reset_lockup_err", 32'(lockup_err), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        clk_en  = 1'b0;
        @(posedge clk);
        #1;

        // free-run: two full periods
        for (int i = 0; i < 30; i++) begin
            expect_out(run_seq[i % 15], (i % 15) == 14, (i >= 14) ? 4'd15 : 4'd0, 1'b0);
            drive(1'b1, MODE_RUN, 1'b0, '0);
        end
        drive(1'b0, MODE_RUN, 1'b0, '0);
        check("two_clear_pulses", 32'(clr_cnt), 32'd2);
        check("clear_spacing", 32'(clr_last - clr_prev), 32'd15);

        // single-step with gaps, then hold and disabled clock enable
        v0 = valid_cnt;
        for (int k = 0; k < 3; k++) begin
            expect_out(step_seq[k], 1'b0, 4'd15, 1'b0);
            drive(1'b1, MODE_STEP, 1'b1, '0);
            repeat (5) drive(1'b1, MODE_STEP, 1'b0, '0);
        end
        repeat (4) drive(1'b1, MODE_HOLD, 1'b1, '0);
        repeat (4) drive(1'b0, MODE_RUN, 1'b1, '0);
        check("step_valid_count", 32'(valid_cnt - v0), 32'd3);
        check("hold_keeps_y", 32'(y_u), 32'hF);

        // load A with step also high (load wins), then run back to SEED
        c0 = clr_cnt;
        expect_out(4'hA, 1'b0, 4'd15, 1'b0);
        drive(1'b1, MODE_LOAD, 1'b1, 4'hA);
        for (int i = 0; i < 9; i++) begin
            expect_out(load_seq[i], i == 8, (i == 8) ? 4'd9 : 4'd15, 1'b0);
            drive(1'b1, MODE_RUN, 1'b0, '0);
        end
        drive(1'b0, MODE_RUN, 1'b0, '0);
        check("load_clear_count", 32'(clr_cnt - c0), 32'd1);

        // lock-up: zero load recovers to SEED, flag sticks through another load
        expect_out(4'h1, 1'b0, 4'd9, 1'b1);
        drive(1'b1, MODE_LOAD, 1'b0, 4'h0);
        expect_out(4'h5, 1'b0, 4'd9, 1'b1);
        drive(1'b1, MODE_LOAD, 1'b0, 4'h5);
        for (int i = 0; i < 13; i++) begin
            expect_out(lock_seq[i], i == 7, (i >= 7) ? 4'd8 : 4'd9, 1'b1);
            drive(1'b1, MODE_RUN, 1'b0, '0);
        end
        drive(1'b0, MODE_RUN, 1'b0, '0);
        check("lockup_sticky", 32'(lockup_err), 32'h1);
        check("pre_reset_y", 32'(y_u), 32'hD);

        // asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check("async_y", 32'(y_u), 32'h1);
        check("async_y_valid", 32'(y_valid), 32'h0);
        check("async_clear_accum", 32'(clear_accum), 32'h0);
        check("async_period_len", 32'(period_len), 32'h0);
        check("async_lockup_err", 32'(lockup_err), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // first advances after release start from SEED
        expect_out(4'h3, 1'b0, 4'd0, 1'b0);
        drive(1'b1, MODE_RUN, 1'b0, '0);
        expect_out(4'h7, 1'b0, 4'd0, 1'b0);
        drive(1'b1, MODE_RUN, 1'b0, '0);
        repeat (2) drive(1'b0, MODE_RUN, 1'b0, '0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
